// File: rtl/cve2_dummy_insert_stage.sv
// IF->ID insertion register: loads a real fetch or a generator dummy, tags dummies,
// caps back-to-back dummies so real fetches are never starved, and counts inserted dummies.
module cve2_dummy_insert_stage #(
  parameter int unsigned MaxConsecDummy = 3,
  parameter int unsigned CntW           = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            fetch_valid_i,
  input  logic [31:0]     fetch_rdata_i,
  input  logic [31:0]     fetch_addr_i,
  input  logic            fetch_err_i,
  output logic            fetch_ready_o,
  input  logic            insert_dummy_instr_i,
  input  logic [31:0]     dummy_instr_data_i,
  output logic            dummy_ack_o,
  input  logic            id_in_ready_i,
  output logic            instr_valid_id_o,
  output logic [31:0]     instr_rdata_id_o,
  output logic [31:0]     instr_addr_id_o,
  output logic            instr_fetch_err_o,
  output logic            instr_is_dummy_o,
  output logic [CntW-1:0] dummy_cnt_o
);

  localparam int unsigned ConsecW = $clog2(MaxConsecDummy + 1);
  localparam logic [ConsecW-1:0] ConsecMax = ConsecW'(MaxConsecDummy);

  // state encoding is {valid, is_dummy}
  localparam logic [1:0] StEmpty = 2'b00;
  localparam logic [1:0] StReal  = 2'b10;
  localparam logic [1:0] StDummy = 2'b11;

  logic [1:0]         state_q, state_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        addr_q, addr_d;
  logic               err_q, err_d;
  logic [ConsecW-1:0] consec_q, consec_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic load_en;
  logic at_cap;
  logic take_dummy;
  logic drop;
  logic take_real;

  assign load_en    = ~flush_i & (~state_q[1] | id_in_ready_i);
  assign at_cap     = (consec_q == ConsecMax);
  assign take_dummy = load_en & insert_dummy_instr_i & ~at_cap;
  assign drop       = load_en & insert_dummy_instr_i & at_cap;
  assign take_real  = load_en & fetch_valid_i & ~take_dummy;

  // A dropped dummy is still acknowledged so the generator moves on.
  assign dummy_ack_o   = ~rst_i & load_en & insert_dummy_instr_i;
  assign fetch_ready_o = ~rst_i & take_real;

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    err_d    = err_q;
    consec_d = consec_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      state_d  = StEmpty;
      consec_d = '0;
    end else if (load_en) begin
      if (take_dummy) begin
        state_d  = StDummy;
        rdata_d  = dummy_instr_data_i;
        addr_d   = fetch_addr_i;
        err_d    = 1'b0;
        consec_d = consec_q + 1'b1;
        if (cnt_q != {CntW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (take_real) begin
        state_d  = StReal;
        rdata_d  = fetch_rdata_i;
        addr_d   = fetch_addr_i;
        err_d    = fetch_err_i;
        consec_d = '0;
      end else begin
        state_d = StEmpty;
        // bubbles keep the run length; only a drop restarts it here
        if (drop) begin
          consec_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StEmpty;
      rdata_q  <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
      consec_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      consec_q <= consec_d;
      cnt_q    <= cnt_d;
    end
  end

  assign instr_valid_id_o  = state_q[1];
  assign instr_is_dummy_o  = state_q[0];
  assign instr_rdata_id_o  = rdata_q;
  assign instr_addr_id_o   = addr_q;
  assign instr_fetch_err_o = err_q;
  assign dummy_cnt_o       = cnt_q;

  ack_pair_only_on_drop: assert property (@(posedge clk_i) disable iff (rst_i)
    (fetch_ready_o && dummy_ack_o) |-> drop);

  unused_state_never_seen: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == StEmpty) || (state_q == StReal) || (state_q == StDummy));

endmodule
